sudoku_game_ctrl: RTL and testbench

Game sequencer for the 4x4 Sudoku Master board. It owns the board register file, the given-cell (write-protect) mask and the cursor. It turns button and write-switch edges into cursor moves and cell writes, then scans all rows, columns and boxes for a win. It also runs the BCD play timer that the top level feeds to the seven-segment displays.

---
 rtl/sudoku_pkg.sv | 36 +++
 rtl/sudoku_group_check.sv | 28 ++
 rtl/sudoku_game_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sudoku_game_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared sizes, FSM state encoding and group-to-cell mapping for the 4x4 Sudoku controller.
package sudoku_pkg;
   localparam int GRID       = 4;
   localparam int CELL_W     = 4;
   localparam int MAX_VAL    = 4;
   localparam int NUM_GROUPS = 12;
   localparam int NUM_CELLS  = GRID * GRID;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLAY  = 3'd1,
      WRITE = 3'd2,
      CHECK = 3'd3,
      WIN   = 3'd4
   } state_t;

   typedef logic [GRID-1:0][3:0] cell_idx_t;

   // Groups 0-3 are rows, 4-7 columns, 8-11 the 2x2 boxes in raster order.
   function automatic cell_idx_t group_cells(input logic [3:0] g);
      cell_idx_t  idx;
      logic [1:0] n;
      logic [1:0] kk;
      n = g[1:0];
      for (int k = 0; k < GRID; k++) begin
         kk = 2'(k);
         if (g < 4'd4)
            idx[k] = {n, kk};
         else if (g < 4'd8)
            idx[k] = {kk, n};
         else
            idx[k] = {n[1], kk[1], n[0], kk[0]};
      end
      return idx;
   endfunction
endpackage

// File: rtl/sudoku_group_check.sv
// Combinational test of one row/column/box: valid when the cells are exactly {1..MAX_VAL},
// dup when any nonzero value appears more than once.
module sudoku_group_check
   import sudoku_pkg::*;
(
   input  logic [GRID-1:0][CELL_W-1:0] i_cells,
   output logic                        o_valid,
   output logic                        o_dup
);
   logic [MAX_VAL-1:0] w_seen;

   always_comb begin
      o_dup  = 1'b0;
      w_seen = '0;
      for (int a = 0; a < GRID; a++) begin
         for (int b = a + 1; b < GRID; b++) begin
            if (i_cells[a] != '0 && i_cells[a] == i_cells[b])
               o_dup = 1'b1;
         end
         for (int v = 1; v <= MAX_VAL; v++) begin
            if (i_cells[a] == CELL_W'(v))
               w_seen[v-1] = 1'b1;
         end
      end
      // Four cells covering all four values can only be a permutation.
      o_valid = &w_seen;
   end
endmodule

// File: rtl/sudoku_game_ctrl.sv
// Sudoku game sequencer: board/given/cursor ownership, edge-driven moves and writes, 12-step win scan, BCD timer.
// Optional `conflict` hint output is built only when CONFLICT_HINT_EN is defined.
module sudoku_game_ctrl
   import sudoku_pkg::*;
#(
   parameter int TICK_DIV = 50000000,
   parameter int TIME_MAX = 99
)(
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  userNum,
   input  logic        upButton,
   input  logic        downButton,
   input  logic        leftButton,
   input  logic        rightButton,
   input  logic        writeSwitch,
   input  logic        load_puzzle,
   input  logic [63:0] puzzle,
   output logic [63:0] board,
   output logic [1:0]  cur_row,
   output logic [1:0]  cur_col,
   output logic [15:0] rowNums,
   output logic [3:0]  currentNum,
   output logic        wpInd,
   output logic        winInd,
   output logic [3:0]  time_ones,
   output logic [3:0]  time_tens
`ifdef CONFLICT_HINT_EN
   ,
   output logic        conflict
`endif
);
   localparam int            PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
   localparam logic [3:0]    MAX_TENS  = 4'(TIME_MAX / 10);
   localparam logic [3:0]    MAX_ONES  = 4'(TIME_MAX % 10);

   state_t                           r_state;
   logic [NUM_CELLS-1:0][CELL_W-1:0] r_board;
   logic [NUM_CELLS-1:0]             r_given;
   logic [1:0]                       r_row;
   logic [1:0]                       r_col;
   logic [3:0]                       r_grp;
   logic [CELL_W-1:0]                r_wval;
   logic                             r_win;
   logic [PW-1:0]                    r_presc;
   logic [3:0]                       r_ones;
   logic [3:0]                       r_tens;
   logic [4:0]                       r_hist;  // {write, right, left, down, up}

   logic [4:0]                  w_lvl;
   logic [4:0]                  w_edge;
   logic [3:0]                  w_cur;
   cell_idx_t                   w_gidx;
   logic [GRID-1:0][CELL_W-1:0] w_gcells;
   logic                        w_gvalid;
   logic                        w_gdup;
   logic                        w_wr_ok;
   logic                        w_run;
   logic                        w_tick;
   logic                        w_sat;

   assign w_lvl   = {writeSwitch, rightButton, leftButton, downButton, upButton};
   assign w_edge  = w_lvl & ~r_hist;
   assign w_cur   = {r_row, r_col};
   assign w_wr_ok = w_edge[4] && !r_given[w_cur] && (userNum <= CELL_W'(MAX_VAL));
   assign w_run   = (r_state == PLAY) || (r_state == WRITE) || (r_state == CHECK);
   assign w_tick  = w_run && (r_presc == PRESC_TOP);
   assign w_sat   = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
   assign w_gidx  = group_cells(r_grp);

   always_comb begin
      for (int k = 0; k < GRID; k++)
         w_gcells[k] = r_board[w_gidx[k]];
   end

   sudoku_group_check u_group_check (
      .i_cells (w_gcells),
      .o_valid (w_gvalid),
      .o_dup   (w_gdup)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_board <= '0;
         r_given <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_grp   <= '0;
         r_wval  <= '0;
         r_win   <= 1'b0;
         r_hist  <= '0;
      end else begin
         r_hist <= w_lvl;
         if (load_puzzle) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
               if (puzzle[i*CELL_W +: CELL_W] > CELL_W'(MAX_VAL)) begin
                  r_board[i] <= '0;
                  r_given[i] <= 1'b0;
               end else begin
                  r_board[i] <= puzzle[i*CELL_W +: CELL_W];
                  r_given[i] <= (puzzle[i*CELL_W +: CELL_W] != '0);
               end
            end
            r_row   <= '0;
            r_col   <= '0;
            r_win   <= 1'b0;
            r_state <= PLAY;
         end else begin
            case (r_state)
               PLAY: begin
                  // An accepted write swallows any button edge of the same cycle.
                  if (w_wr_ok) begin
                     r_wval  <= userNum;
                     r_state <= WRITE;
                  end else if (w_edge[0]) r_row <= r_row - 2'd1;
                  else if (w_edge[1])     r_row <= r_row + 2'd1;
                  else if (w_edge[2])     r_col <= r_col - 2'd1;
                  else if (w_edge[3])     r_col <= r_col + 2'd1;
               end
               WRITE: begin
                  r_board[w_cur] <= r_wval;
                  r_grp          <= '0;
                  r_state        <= CHECK;
               end
               CHECK: begin
                  if (!w_gvalid)
                     r_state <= PLAY;
                  else if (r_grp == 4'(NUM_GROUPS - 1)) begin
                     r_state <= WIN;
                     r_win   <= 1'b1;
                  end else
                     r_grp <= r_grp + 4'd1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_presc <= '0;
         r_ones  <= '0;
         r_tens  <= '0;
      end else if (load_puzzle) begin
         r_presc <= '0;
         r_ones  <= '0;
         r_tens  <= '0;
      end else if (w_run) begin
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
         if (w_tick && !w_sat) begin
            if (r_ones == 4'd9) begin
               r_ones <= '0;
               r_tens <= r_tens + 4'd1;
            end else
               r_ones <= r_ones + 4'd1;
         end
      end
   end

`ifdef CONFLICT_HINT_EN
   logic r_conflict;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         r_conflict <= 1'b0;
      else if (load_puzzle || r_state == WRITE)
         r_conflict <= 1'b0;
      else if (r_state == CHECK && !w_gvalid && w_gdup)
         r_conflict <= 1'b1;
   end

   assign conflict = r_conflict;
`else
   logic w_dup_unused;
   assign w_dup_unused = w_gdup;
`endif

   always_comb begin
      for (int k = 0; k < GRID; k++)
         rowNums[k*CELL_W +: CELL_W] = r_board[{r_row, 2'(k)}];
   end

   assign board      = r_board;
   assign cur_row    = r_row;
   assign cur_col    = r_col;
   assign currentNum = r_board[w_cur];
   assign wpInd      = r_given[w_cur];
   assign winInd     = r_win;
   assign time_ones  = r_ones;
   assign time_tens  = r_tens;
endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Scoreboard bench for sudoku_game_ctrl: directed stimulus queues expected outputs,
// a negedge monitor pops and compares them. Conflict checks are built with CONFLICT_HINT_EN.
module tb_sudoku_game_ctrl;
   localparam int SEL_BOARD = 0, SEL_ROW = 1, SEL_COL = 2, SEL_ROWN = 3, SEL_CUR = 4;
   localparam int SEL_WP = 5, SEL_WIN = 6, SEL_TIME = 7, SEL_CONF = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [3:0]  userNum = '0;
   logic [3:0]  btn = '0;  // {right, left, down, up}
   logic        writeSwitch = 1'b0;
   logic        load_puzzle = 1'b0;
   logic [63:0] puzzle = '0;
   logic [63:0] board;
   logic [1:0]  cur_row;
   logic [1:0]  cur_col;
   logic [15:0] rowNums;
   logic [3:0]  currentNum;
   logic        wpInd;
   logic        winInd;
   logic [3:0]  time_ones;
   logic [3:0]  time_tens;
`ifdef CONFLICT_HINT_EN
   logic        conflict;
`endif

   sudoku_game_ctrl #(.TICK_DIV(4), .TIME_MAX(99)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .userNum     (userNum),
      .upButton    (btn[0]),
      .downButton  (btn[1]),
      .leftButton  (btn[2]),
      .rightButton (btn[3]),
      .writeSwitch (writeSwitch),
      .load_puzzle (load_puzzle),
      .puzzle      (puzzle),
      .board       (board),
      .cur_row     (cur_row),
      .cur_col     (cur_col),
      .rowNums     (rowNums),
      .currentNum  (currentNum),
      .wpInd       (wpInd),
      .winInd      (winInd),
      .time_ones   (time_ones),
      .time_tens   (time_tens)
`ifdef CONFLICT_HINT_EN
      ,
      .conflict    (conflict)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      int          sel;
      logic [63:0] exp;
   } chk_t;

   chk_t q[$];
   chk_t mon_c;
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic logic [63:0] actual(input int sel);
      case (sel)
         SEL_BOARD: return board;
         SEL_ROW:   return 64'(cur_row);
         SEL_COL:   return 64'(cur_col);
         SEL_ROWN:  return 64'(rowNums);
         SEL_CUR:   return 64'(currentNum);
         SEL_WP:    return 64'(wpInd);
         SEL_WIN:   return 64'(winInd);
         SEL_TIME:  return 64'({time_tens, time_ones});
`ifdef CONFLICT_HINT_EN
         SEL_CONF:  return 64'(conflict);
`endif
         default:   return 'x;
      endcase
   endfunction

   always @(negedge CLK) begin
      while (q.size() > 0) begin
         mon_c = q.pop_front();
         n_checks++;
         if (actual(mon_c.sel) !== mon_c.exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", mon_c.name, actual(mon_c.sel), mon_c.exp);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int sel, input logic [63:0] v);
      chk_t c;
      c.name = nm;
      c.sel  = sel;
      c.exp  = v;
      q.push_back(c);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic press(input logic [3:0] m);
      btn = m;
      tick();
      btn = '0;
      tick();
   endtask

   task automatic do_write(input logic [3:0] v);
      userNum     = v;
      writeSwitch = 1'b1;
      tick();
      writeSwitch = 1'b0;
      tick();
   endtask

   task automatic load(input logic [63:0] p);
      puzzle      = p;
      load_puzzle = 1'b1;
      tick();
      load_puzzle = 1'b0;
   endtask

   task automatic chk_cursor(input string nm, input logic [1:0] r, input logic [1:0] c);
      chk({nm, "_row"}, SEL_ROW, 64'(r));
      chk({nm, "_col"}, SEL_COL, 64'(c));
   endtask

   function automatic logic [63:0] pack_sol();
      int          v [16] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[i*4 +: 4] = 4'(v[i]);
      return r;
   endfunction

   function automatic logic [15:0] row_of(input logic [63:0] b, input int r);
      return b[r*16 +: 16];
   endfunction

   initial begin
      logic [63:0] sol, p1, eb, p2;
      sol = pack_sol();
      p1 = sol;
      p1[1*4 +: 4]  = 4'd0;
      p1[15*4 +: 4] = 4'd0;
      p1[10*4 +: 4] = 4'd9;
      eb = p1;
      eb[10*4 +: 4] = 4'd0;
      p2 = sol;
      p2[15*4 +: 4] = 4'd0;

      #2;
      chk("rst_board", SEL_BOARD, 64'd0);
      chk_cursor("rst", 2'd0, 2'd0);
      chk("rst_win", SEL_WIN, 64'd0);
      chk("rst_time", SEL_TIME, 64'h00);
      tick();
      RST = 1'b1;
      press(4'b0001);
      chk("idle_up_ignored", SEL_ROW, 64'd0);

      load(p1);
      chk("load_board", SEL_BOARD, eb);
      n_checks++;
      if (board !== eb) begin
         n_errors++;
         $display("FAIL load_board_direct: got %0h, expected %0h", board, eb);
      end
      chk_cursor("load", 2'd0, 2'd0);
      chk("load_cur", SEL_CUR, 64'd1);
      chk("load_wp", SEL_WP, 64'd1);
      chk("load_rownums", SEL_ROWN, 64'(row_of(eb, 0)));
      chk("load_time", SEL_TIME, 64'h00);
      chk("load_win", SEL_WIN, 64'd0);
`ifdef CONFLICT_HINT_EN
      chk("load_conflict", SEL_CONF, 64'd0);
`endif

      press(4'b0001);
      chk("up_wrap", SEL_ROW, 64'd3);
      press(4'b0100);
      chk("left_wrap", SEL_COL, 64'd3);
      chk("cur_33", SEL_CUR, 64'd0);
      chk("wp_33", SEL_WP, 64'd0);
      chk("rownums_r3", SEL_ROWN, 64'(row_of(eb, 3)));
      press(4'b0101);
      chk_cursor("up_left_prio", 2'd2, 2'd3);
      chk("cur_23", SEL_CUR, 64'd3);
      press(4'b0010);
      press(4'b0010);
      press(4'b1000);
      chk_cursor("down_right_wrap", 2'd0, 2'd0);

      do_write(4'd3);
      chk("wp_write_board", SEL_BOARD, eb);
      press(4'b1000);
      chk("after_wp_still_play", SEL_COL, 64'd1);
      chk("wp_01", SEL_WP, 64'd0);

      do_write(4'd7);
      chk("big_val_board", SEL_BOARD, eb);
      press(4'b0100);
      press(4'b1000);
      chk("after_big_still_play", SEL_COL, 64'd1);

      userNum     = 4'd1;
      writeSwitch = 1'b1;
      tick();
      writeSwitch = 1'b0;
      tick();
      eb[1*4 +: 4] = 4'd1;
      chk("dup_commit", SEL_BOARD, eb);
      tick();
      press(4'b1000);
      chk("dup_abort_play", SEL_COL, 64'd2);
      chk("dup_win", SEL_WIN, 64'd0);
`ifdef CONFLICT_HINT_EN
      chk("dup_conflict_set", SEL_CONF, 64'd1);
`endif
      press(4'b0100);
      chk("back_01_cur", SEL_CUR, 64'd1);

      do_write(4'd2);
      eb[1*4 +: 4] = 4'd2;
      chk("fix_commit", SEL_BOARD, eb);
`ifdef CONFLICT_HINT_EN
      chk("conflict_cleared", SEL_CONF, 64'd0);
`endif
      repeat (14) tick();
      press(4'b0010);
      press(4'b0010);
      press(4'b1000);
      chk_cursor("to_22", 2'd2, 2'd2);
      chk("wp_forced_zero", SEL_WP, 64'd0);
      do_write(4'd4);
      repeat (14) tick();
      eb[10*4 +: 4] = 4'd4;
      chk("write_22", SEL_BOARD, eb);
      chk("rownums_r2", SEL_ROWN, 64'(row_of(eb, 2)));
      chk("partial_win", SEL_WIN, 64'd0);

      load(p1);
      chk("tmr_start", SEL_TIME, 64'h00);
      repeat (39) tick();
      chk("tmr_09", SEL_TIME, 64'h09);
      tick();
      chk("tmr_10", SEL_TIME, 64'h10);
      repeat (359) tick();
      chk("tmr_99", SEL_TIME, 64'h99);
      repeat (40) tick();
      chk("tmr_sat", SEL_TIME, 64'h99);

      load(p2);
      chk("p2_board", SEL_BOARD, p2);
      press(4'b0001);
      press(4'b0100);
      chk_cursor("p2_33", 2'd3, 2'd3);
      userNum     = 4'd1;
      writeSwitch = 1'b1;
      tick();
      writeSwitch = 1'b0;
      tick();
      chk("win_early", SEL_WIN, 64'd0);
      repeat (13) tick();
      chk("win_set", SEL_WIN, 64'd1);
      n_checks++;
      if (winInd !== 1'b1) begin
         n_errors++;
         $display("FAIL win_set_direct: got %0b, expected 1", winInd);
      end
      chk("win_board", SEL_BOARD, sol);
      chk("win_time", SEL_TIME, 64'h04);
      repeat (1000) tick();
      chk("win_time_frozen", SEL_TIME, 64'h04);
      chk("win_held", SEL_WIN, 64'd1);
      press(4'b0001);
      chk_cursor("win_cursor_frozen", 2'd3, 2'd3);

      load(p2);
      chk("reload_win", SEL_WIN, 64'd0);
      chk_cursor("reload", 2'd0, 2'd0);
      press(4'b0001);
      press(4'b0100);
      userNum     = 4'd1;
      writeSwitch = 1'b1;
      tick();
      writeSwitch = 1'b0;
      tick();
      tick();
      tick();
      RST = 1'b0;
      #1;
      chk("midchk_rst_board", SEL_BOARD, 64'd0);
      chk("midchk_rst_win", SEL_WIN, 64'd0);
      chk("midchk_rst_time", SEL_TIME, 64'h00);
      chk_cursor("midchk_rst", 2'd0, 2'd0);
      n_checks++;
      if (cur_row !== 2'd0 || cur_col !== 2'd0) begin
         n_errors++;
         $display("FAIL midchk_rst_cursor_direct: got (%0d,%0d), expected (0,0)", cur_row, cur_col);
      end
`ifdef CONFLICT_HINT_EN
      chk("midchk_rst_conflict", SEL_CONF, 64'd0);
`endif
      tick();
      tick();
      RST = 1'b1;
      press(4'b0001);
      press(4'b0100);
      chk_cursor("post_rst_idle", 2'd0, 2'd0);
      chk("post_rst_time", SEL_TIME, 64'h00);

      @(negedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      if (n_errors == 0 && n_checks >= 12)
         $display("PASS");
      else
         $display("FAIL");
      $finish;
   end
endmodule
